// File: rtl/wifi_rx_pkg.sv
// Shared definitions for the WiFi UART receive peripheral.
// Register offsets, STATUS bit positions and receiver FSM encoding.
// No logic; imported by the receiver core and the bus-facing top.
package wifi_rx_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h2;
  localparam logic [3:0] ADDR_CLEAR  = 4'h4;
  localparam logic [3:0] ADDR_COUNT  = 4'h6;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_BUSY      = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronizer, baud counter and framing FSM.
// Latency: byte_valid pulses in the stop-bit sample cycle (~9.5 bits + 2 clk after start edge).
// No backpressure: the consumer must take rx_byte on the byte_valid pulse.
module uart_rx_core
  import wifi_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic            rx_meta, rx_s;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM, baud counter, bit index and shift register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic; start bit is checked at mid-bit, later bits one full bit apart.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line that is high again at mid-start was only a glitch.
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_valid = 1'b1;
            state_d    = IDLE;
          end else begin
            // Hold off until the line recovers so a break reports one error.
            frame_err = 1'b1;
            state_d   = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_byte = shift_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: rtl/peripheral_wifi_rx.sv
// J1 I/O peripheral: buffers WiFi UART bytes in a FIFO, exposes DATA/STATUS/COUNT, level irq.
// Latency: byte visible in STATUS/COUNT one cycle after the stop-bit sample; reads are combinational.
// No backpressure to the line: a byte arriving on a full FIFO is dropped and sets sticky overrun.
module peripheral_wifi_rx
  import wifi_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  input  logic        rx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  rx_byte;
  logic        byte_valid, frame_err, busy;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_d;
  logic        empty, full;
  logic        rd_data_term, rd_data_q, pop, push;
  logic        clear_wr, flush, overrun_set;
  logic        overrun, framing_err;
  logic        unused_d_in;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  assign empty        = (count == '0);
  assign full         = (count == (AW+1)'(FIFO_DEPTH));
  assign rd_data_term = cs && rd && (addr == ADDR_DATA);
  // One pop per read access, however long the strobe is held.
  assign pop          = rd_data_term && !rd_data_q && !empty;
  assign clear_wr     = cs && wr && (addr == ADDR_CLEAR);
  assign flush        = clear_wr && d_in[2];
  // A full FIFO still accepts the byte when the head leaves in the same cycle.
  assign push         = byte_valid && (!full || pop) && !flush;
  assign overrun_set  = byte_valid && full && !pop && !flush;
  assign unused_d_in  = ^d_in[15:3];

  // Occupancy after this cycle's flush/push/pop.
  always_comb begin
    count_d = count;
    if (flush)              count_d = '0;
    else if (push && !pop)  count_d = count + 1'b1;
    else if (pop && !push)  count_d = count - 1'b1;
  end

  // FIFO pointers, occupancy, read-edge detect and registered irq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data_q <= 1'b0;
      irq       <= 1'b0;
    end else begin
      rd_data_q <= rd_data_term;
      count     <= count_d;
      irq       <= (count_d != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Byte storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_byte;
  end

  // Sticky error flags; a same-cycle set beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      overrun     <= (overrun && !(clear_wr && d_in[0])) || overrun_set;
      framing_err <= (framing_err && !(clear_wr && d_in[1])) || frame_err;
    end
  end

  // Read mux; anything but a selected read of a readable register gives 0.
  always_comb begin
    d_out = '0;
    if (cs && rd) begin
      case (addr)
        ADDR_DATA:   d_out = empty ? 16'h0000 : {8'h00, mem[rd_ptr]};
        ADDR_STATUS: begin
          d_out[ST_NOT_EMPTY] = !empty;
          d_out[ST_FULL]      = full;
          d_out[ST_OVERRUN]   = overrun;
          d_out[ST_FRAME_ERR] = framing_err;
          d_out[ST_BUSY]      = busy;
        end
        ADDR_COUNT:  d_out = 16'(count);
        default:     d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_wifi_rx.sv
// Scoreboard bench for peripheral_wifi_rx: directed UART frames and J1 bus accesses.
// Expected read data/irq are queued by the stimulus; a negedge monitor pops and compares.
// Runs with a short bit time to keep the simulation small.
module tb_peripheral_wifi_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_in;
  logic        cs, rd, wr;
  logic [3:0]  addr;
  logic [15:0] d_out;
  logic        rx;
  logic        irq;

  int tests = 0;
  int fails = 0;

  string       q_name[$];
  logic [15:0] q_dout[$];
  int          q_irq[$];

  string       m_name;
  logic [15:0] m_dout;
  int          m_irq;

  peripheral_wifi_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out),
    .rx    (rx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle with a selected read consumes one expectation.
  always @(negedge clk) begin
    if (cs && rd) begin
      tests++;
      if (q_dout.size() == 0) begin
        fails++;
        $display("FAIL unexpected_read: addr=%h d_out=%h, no expectation queued", addr, d_out);
      end else begin
        m_name = q_name.pop_front();
        m_dout = q_dout.pop_front();
        m_irq  = q_irq.pop_front();
        if (d_out !== m_dout || (m_irq >= 0 && irq !== m_irq[0])) begin
          fails++;
          $display("FAIL %s: got d_out=%h irq=%b, expected d_out=%h irq=%0d",
                   m_name, d_out, irq, m_dout, m_irq);
        end
      end
    end
  end

  task automatic push_exp(input string n, input logic [15:0] v, input int ei);
    q_name.push_back(n);
    q_dout.push_back(v);
    q_irq.push_back(ei);
  endtask

  task automatic bus_read(input logic [3:0] a, input int cycles);
    @(posedge clk); #1;
    cs = 1'b1; rd = 1'b1; addr = a;
    repeat (cycles) @(posedge clk);
    #1;
    cs = 1'b0; rd = 1'b0; addr = 4'h0;
  endtask

  task automatic exp_read(input string n, input logic [3:0] a, input logic [15:0] v, input int ei);
    push_exp(n, v, ei);
    bus_read(a, 1);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] v);
    @(posedge clk); #1;
    cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0000;
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_v, input int stop_bits);
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1 rx = stop_v;
    repeat (CPB * stop_bits) @(posedge clk);
    #1 rx = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  // Watchdog: the bench always reaches its summary.
  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0000; rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // Reset state
    exp_read("reset_status", 4'h2, 16'h0000, 0);
    exp_read("reset_count",  4'h6, 16'h0000, 0);
    exp_read("reset_data",   4'h0, 16'h0000, 0);
    exp_read("unmapped_rd",  4'h8, 16'h0000, 0);

    // Single byte
    uart_send(8'h41, 1'b1, 1);
    exp_read("a_status",     4'h2, 16'h0001, 1);
    exp_read("a_count",      4'h6, 16'h0001, 1);
    exp_read("a_data",       4'h0, 16'h0041, 1);
    exp_read("a_status_pop", 4'h2, 16'h0000, 0);

    // Short low glitch is ignored
    @(posedge clk); #1 rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    exp_read("glitch_status", 4'h2, 16'h0000, 0);
    exp_read("glitch_count",  4'h6, 16'h0000, 0);

    // Framing error from a held-low stop bit, then clear and recover
    uart_send(8'h55, 1'b0, 3);
    exp_read("ferr_status", 4'h2, 16'h0008, 0);
    exp_read("ferr_count",  4'h6, 16'h0000, 0);
    bus_write(4'h4, 16'h0002);
    exp_read("ferr_cleared", 4'h2, 16'h0000, 0);
    uart_send(8'h5A, 1'b1, 1);
    exp_read("recover_status", 4'h2, 16'h0001, 1);
    exp_read("recover_data",   4'h0, 16'h005A, 1);

    // Overflow: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) uart_send(8'(i), 1'b1, 1);
    exp_read("ovf_count",  4'h6, 16'h0010, 1);
    exp_read("ovf_status", 4'h2, 16'h0007, 1);
    for (int i = 0; i < 16; i++)
      exp_read($sformatf("ovf_data_%0d", i), 4'h0, 16'(i), 1);
    exp_read("ovf_drained_count", 4'h6, 16'h0000, 0);
    exp_read("ovf_empty_data",    4'h0, 16'h0000, 0);
    exp_read("ovf_sticky",        4'h2, 16'h0004, 0);
    bus_write(4'h4, 16'h0001);
    exp_read("ovf_cleared",       4'h2, 16'h0000, 0);

    // Held read strobe pops once; d_out tracks the new head afterwards
    uart_send(8'hA1, 1'b1, 1);
    uart_send(8'hA2, 1'b1, 1);
    uart_send(8'hA3, 1'b1, 1);
    exp_read("hold_count_pre", 4'h6, 16'h0003, 1);
    push_exp("hold_c0", 16'h00A1, 1);
    for (int i = 1; i < 5; i++) push_exp($sformatf("hold_c%0d", i), 16'h00A2, 1);
    bus_read(4'h0, 5);
    exp_read("hold_count_post", 4'h6, 16'h0002, 1);
    exp_read("hold_next",       4'h0, 16'h00A2, 1);

    // Flush drops the remaining byte
    bus_write(4'h4, 16'h0004);
    exp_read("flush_count",  4'h6, 16'h0000, 0);
    exp_read("flush_status", 4'h2, 16'h0000, 0);

    // Reset mid-frame with two bytes buffered
    uart_send(8'h11, 1'b1, 1);
    uart_send(8'h22, 1'b1, 1);
    exp_read("pre_rst_count", 4'h6, 16'h0002, 1);
    @(posedge clk); #1 rx = 1'b0;
    repeat (CPB + CPB / 2) @(posedge clk);
    #1 rst = 1'b1; rx = 1'b1;
    exp_read("rst_status", 4'h2, 16'h0000, 0);
    exp_read("rst_count",  4'h6, 16'h0000, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2 * CPB) @(posedge clk);
    exp_read("post_rst_status", 4'h2, 16'h0000, 0);
    uart_send(8'h0D, 1'b1, 1);
    exp_read("post_rst_rx_status", 4'h2, 16'h0001, 1);
    exp_read("post_rst_data",      4'h0, 16'h000D, 1);
    exp_read("post_rst_count",     4'h6, 16'h0000, 0);

    repeat (4) @(posedge clk);
    if (q_dout.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL leftover_expectations: %0d pending, expected 0", q_dout.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/peripheral_wifi_rx.md
Name: peripheral_wifi_rx

Overview:
- J1 SoC memory-mapped peripheral that receives 8N1 UART bytes from the WiFi module (replies, acks, "OK"/"ERROR" strings).
- Complements the existing TX/command peripheral on the same link.
- Buffers received bytes in a FIFO, exposes data/status/count registers on the J1 I/O bus, and drives a level interrupt while data is pending.

Parameters:
- CLKS_PER_BIT, 434, system clocks per UART bit (50 MHz / 115200); must be >= 8.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..256.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- d_in  in  16  J1 write data.
- cs  in  1  peripheral chip select.
- addr  in  4  4 LSBs of the J1 I/O address.
- rd  in  1  J1 read strobe (level; may stay high several cycles).
- wr  in  1  J1 write strobe.
- d_out  out  16  read data; combinational mux, 0 when not selected.
- rx  in  1  UART line from WiFi module; asynchronous, idle high.
- irq  out  1  high while FIFO is non-empty.

Behaviour:
- Reset: FSM IDLE, FIFO empty, sticky flags 0, synchronizer flops 1, irq=0, d_out=0.
- rx passes through a 2-flop synchronizer (rx_s); it is set to 1 on reset.
- Register map:
  - 0x0 RD: DATA = {8'h00, head byte}. Reads 0 when the FIFO is empty.
  - 0x2 RD: STATUS = bit0 not_empty, bit1 full, bit2 overrun (sticky), bit3 framing_err (sticky), bit4 rx_busy (FSM not IDLE), others 0.
  - 0x4 WR: CLEAR. d_in[0]=1 clears overrun; d_in[1]=1 clears framing_err; d_in[2]=1 flushes the FIFO.
  - 0x6 RD: COUNT = number of bytes in the FIFO, zero-extended.
  - Any other address/strobe combination: d_out=0, no side effect.
- Pop: one pop per DATA read access.
  - Pop occurs in the first cycle of cs&&rd&&addr==0, detected by a rising edge against a registered copy of that term.
  - d_out shows the pre-pop head during that cycle.
  - Reading DATA while empty: no pop, no flag.
- Receiver FSM (baud counter cnt):
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: at cnt==CLKS_PER_BIT/2-1, sample. If rx_s==0, go to DATA (cnt=0, bit index 0). Otherwise it was a glitch: return to IDLE with no flag.
  - DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into shift[bit] (LSB first) and reset cnt. After bit 7, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample.
    - rx_s==1: push the byte and go to IDLE.
    - rx_s==0: set framing_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. A break condition therefore produces exactly one framing error.
- Push on full:
  - The byte is dropped and overrun is set, unless a pop occurs in the same cycle; in that case the push is accepted and count is unchanged.
  - Push and pop on a non-full, non-empty FIFO in the same cycle: count unchanged.
  - Push on empty with a same-cycle read: no pop (the empty check uses pre-push state).
- Flush and clear priority:
  - Flush in the same cycle as a push: flush wins, the byte is lost, no overrun.
  - A sticky flag set and cleared in the same cycle ends up set.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.
- Latency: a byte is visible (not_empty=1) 1 cycle after the STOP sample, i.e. about 9.5 bit times plus 2 synchronizer cycles after the start edge.
- irq = not_empty, registered.
- Asynchronous reset mid-frame aborts the frame. After release, the FSM waits in IDLE for the next falling edge; a reset released mid-frame may yield a framing error on the tail of that frame, which is acceptable.

Decomposition:
- Package wifi_rx_pkg: register offsets (DATA=4'h0, STATUS=4'h2, CLEAR=4'h4, COUNT=4'h6), STATUS bit indices, FSM state encoding (IDLE, START, DATA, STOP, WAIT_HIGH).
- Sub-module uart_rx_core: synchronizer, baud counter and FSM. Outputs byte[7:0], byte_valid (1-cycle pulse), frame_err (pulse), busy.
- FIFO and bus decode stay in peripheral_wifi_rx.

Test Plan:
- Send 0x41 at 115200 -> STATUS=0x0001, irq=1, COUNT=1; read 0x0 -> 0x0041; then STATUS=0x0000, irq=0.
- Low glitch on rx of CLKS_PER_BIT/4 cycles -> no byte, STATUS=0x0000 throughout, FSM back to IDLE.
- Frame 0x55 with stop bit driven 0 and held low 3 bit times -> STATUS bit3=1, COUNT=0; write 0x4 with 0x0002 -> STATUS=0x0000; next good 0x5A is received.
- Send 17 bytes 0x00..0x10 with no reads -> COUNT=16, STATUS=0x0007; 16 reads return 0x00..0x0F in order, then empty.
- Hold rd high 5 cycles on addr 0x0 with COUNT=3 -> exactly one pop, COUNT=2; d_out holds the old head for the first cycle.
- Assert rst mid-data-bit of a frame with 2 bytes buffered -> COUNT=0, STATUS=0, irq=0 immediately; the following clean frame 0x0D is received correctly.
